// File: rtl/fdtd_mem_burst_rd_if.sv
// Bundle for fdtd_mem_burst_rd: AXI4 AR/R channels plus the word-request and word-stream ports.
// Latency: none; this interface only carries signals.
// Backpressure: AR uses ARVALID/ARREADY, R and the word stream use valid/ready.
interface fdtd_mem_burst_rd_if #(
    parameter int AXI4_ADDR_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH = 32,
    parameter int AXI4_ID_WIDTH   = 16,
    parameter int AXI4_USER_WIDTH = 10,
    parameter int LEN_WIDTH       = 16
);
    // AXI4 read-address channel
    logic [AXI4_ADDR_WIDTH-1:0] ARADDR_o;
    logic [7:0]                 ARLEN_o;
    logic [2:0]                 ARSIZE_o;
    logic [1:0]                 ARBURST_o;
    logic [AXI4_ID_WIDTH-1:0]   ARID_o;
    logic                       ARLOCK_o;
    logic [3:0]                 ARCACHE_o;
    logic [2:0]                 ARPROT_o;
    logic [3:0]                 ARREGION_o;
    logic [3:0]                 ARQOS_o;
    logic [AXI4_USER_WIDTH-1:0] ARUSER_o;
    logic                       ARVALID_o;
    logic                       ARREADY_i;

    // AXI4 read-data channel
    logic [AXI4_ID_WIDTH-1:0]   RID_i;
    logic [AXI4_DATA_WIDTH-1:0] RDATA_i;
    logic [1:0]                 RRESP_i;
    logic                       RLAST_i;
    logic [AXI4_USER_WIDTH-1:0] RUSER_i;
    logic                       RVALID_i;
    logic                       RREADY_o;

    // Word request and word output stream
    logic                         rd_req_i;
    logic [AXI4_ADDR_WIDTH-3:0]   rd_word_addr_i;
    logic [LEN_WIDTH-1:0]         rd_len_i;
    logic [31:0]                  rd_data_o;
    logic                         rd_valid_o;
    logic                         rd_ready_i;
    logic                         rd_busy_o;
    logic                         rd_done_o;
    logic                         rd_err_o;

    // View of the burst reader itself
    modport master (
        output ARADDR_o, ARLEN_o, ARSIZE_o, ARBURST_o, ARID_o, ARLOCK_o, ARCACHE_o,
               ARPROT_o, ARREGION_o, ARQOS_o, ARUSER_o, ARVALID_o,
        input  ARREADY_i,
        input  RID_i, RDATA_i, RRESP_i, RLAST_i, RUSER_i, RVALID_i,
        output RREADY_o,
        input  rd_req_i, rd_word_addr_i, rd_len_i, rd_ready_i,
        output rd_data_o, rd_valid_o, rd_busy_o, rd_done_o, rd_err_o
    );

    // View of the memory/interconnect and the word consumer
    modport slave (
        input  ARADDR_o, ARLEN_o, ARSIZE_o, ARBURST_o, ARID_o, ARLOCK_o, ARCACHE_o,
               ARPROT_o, ARREGION_o, ARQOS_o, ARUSER_o, ARVALID_o,
        output ARREADY_i,
        output RID_i, RDATA_i, RRESP_i, RLAST_i, RUSER_i, RVALID_i,
        input  RREADY_o,
        output rd_req_i, rd_word_addr_i, rd_len_i, rd_ready_i,
        input  rd_data_o, rd_valid_o, rd_busy_o, rd_done_o, rd_err_o
    );
endinterface

// File: rtl/fdtd_mem_burst_rd.sv
// Splits a word-count read into AXI4 INCR bursts (<= MAX_BURST beats, never crossing 4 KB) and streams words out.
// Latency: AR one cycle after accept; R words pass through combinationally; rd_done_o one cycle after final RLAST.
// Backpressure: rd_ready_i is RREADY_o; one burst outstanding. RRESP error flag enabled by FDTD_MEM_BURST_RD_ERR_CHECK_EN.
module fdtd_mem_burst_rd #(
    parameter int AXI4_ADDR_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH = 32,
    parameter int AXI4_ID_WIDTH   = 16,
    parameter int AXI4_USER_WIDTH = 10,
    parameter int MAX_BURST       = 16,
    parameter int LEN_WIDTH       = 16
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    fdtd_mem_burst_rd_if.master  bus
);
    localparam int WAW = AXI4_ADDR_WIDTH - 2;
    // Compare width: one bit above the count so it never wraps, and at least
    // wide enough to hold the 4 KB room value (1..1024).
    localparam int CW  = (LEN_WIDTH + 1 > 12) ? LEN_WIDTH + 1 : 12;

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_DONE} state_t;

    state_t                     state, state_nxt;
    logic [WAW-1:0]             addr, addr_nxt;
    logic [LEN_WIDTH-1:0]       rem, rem_nxt;
    logic [7:0]                 arlen, arlen_nxt;
    logic [AXI4_DATA_WIDTH-1:0] rdata;
    logic                       accept;
    logic                       beat;

    // Beats-1 for a burst starting at word a with r words left: min(r, MAX_BURST, room to 4 KB).
    function automatic logic [7:0] burst_m1(input logic [WAW-1:0] a, input logic [LEN_WIDTH-1:0] r);
        logic [CW-1:0] b;
        logic [CW-1:0] room;
        b = CW'(r);
        if (b > CW'(MAX_BURST)) b = CW'(MAX_BURST);
        room = CW'(11'd1024 - {1'b0, a[9:0]});
        if (b > room) b = room;
        return 8'(b - CW'(1));
    endfunction

    assign rdata  = bus.RDATA_i;
    assign accept = (state == ST_IDLE) && bus.rd_req_i;
    assign beat   = (state == ST_DATA) && bus.RVALID_i && bus.rd_ready_i;

    // State, address, remaining count and burst length registers.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= ST_IDLE;
            addr  <= '0;
            rem   <= '0;
            arlen <= '0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
            rem   <= rem_nxt;
            arlen <= arlen_nxt;
        end
    end

    // Next-state logic; the burst length is computed on entry to ADDR so that
    // ARLEN_o is a register and stays stable while ARVALID_o waits.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        rem_nxt   = rem;
        arlen_nxt = arlen;
        unique case (state)
            ST_IDLE: begin
                if (bus.rd_req_i) begin
                    addr_nxt  = bus.rd_word_addr_i;
                    rem_nxt   = bus.rd_len_i;
                    state_nxt = (bus.rd_len_i == '0) ? ST_DONE : ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (bus.ARREADY_i) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (beat) begin
                    addr_nxt = addr + WAW'(1);
                    rem_nxt  = rem - LEN_WIDTH'(1);
                    if (bus.RLAST_i) state_nxt = (rem_nxt == '0) ? ST_DONE : ST_ADDR;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (state_nxt == ST_ADDR && state != ST_ADDR) arlen_nxt = burst_m1(addr_nxt, rem_nxt);
    end

    // AR channel: address and length from registers, the rest tied off.
    assign bus.ARVALID_o  = (state == ST_ADDR);
    assign bus.ARADDR_o   = {addr, 2'b00};
    assign bus.ARLEN_o    = arlen;
    assign bus.ARSIZE_o   = 3'd2;
    assign bus.ARBURST_o  = 2'b01;
    assign bus.ARID_o     = {AXI4_ID_WIDTH{1'b0}};
    assign bus.ARLOCK_o   = 1'b0;
    assign bus.ARCACHE_o  = 4'd0;
    assign bus.ARPROT_o   = 3'd0;
    assign bus.ARREGION_o = 4'd0;
    assign bus.ARQOS_o    = 4'd0;
    assign bus.ARUSER_o   = {AXI4_USER_WIDTH{1'b0}};

    // R channel is a straight pass-through to the word stream while in DATA.
    assign bus.RREADY_o   = (state == ST_DATA) && bus.rd_ready_i;
    assign bus.rd_valid_o = (state == ST_DATA) && bus.RVALID_i;
    assign bus.rd_data_o  = rdata;
    assign bus.rd_busy_o  = (state != ST_IDLE);
    assign bus.rd_done_o  = (state == ST_DONE);

`ifdef FDTD_MEM_BURST_RD_ERR_CHECK_EN
    logic err;

    // Sticky SLVERR/DECERR flag, cleared when a new request is accepted.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            err <= 1'b0;
        end else if (accept) begin
            err <= 1'b0;
        end else if (beat && bus.RRESP_i[1]) begin
            err <= 1'b1;
        end
    end

    assign bus.rd_err_o = err;
`else
    assign bus.rd_err_o = 1'b0;
`endif

    // RID/RUSER carry nothing this block needs; RRESP only matters with error checking.
    logic unused_in;
    assign unused_in = ^{bus.RID_i, bus.RUSER_i, bus.RRESP_i, accept};

endmodule

// File: tb/tb_fdtd_mem_burst_rd.sv
// Self-checking bench for fdtd_mem_burst_rd: random AXI slave/consumer timing, queue-based model of bursts and words.
// Latency: model expects rd_done_o one cycle after the last beat (or after accept for len=0).
// Backpressure: ARREADY, RVALID and rd_ready_i are driven with random or scripted stall patterns.
module tb_fdtd_mem_burst_rd;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int IW  = 16;
    localparam int UW  = 10;
    localparam int MB  = 16;
    localparam int LW  = 16;
    localparam int WAW = AW - 2;
`ifdef FDTD_MEM_BURST_RD_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    fdtd_mem_burst_rd_if #(.AXI4_ADDR_WIDTH(AW), .AXI4_DATA_WIDTH(DW), .AXI4_ID_WIDTH(IW),
                           .AXI4_USER_WIDTH(UW), .LEN_WIDTH(LW)) bus ();

    fdtd_mem_burst_rd #(.AXI4_ADDR_WIDTH(AW), .AXI4_DATA_WIDTH(DW), .AXI4_ID_WIDTH(IW),
                        .AXI4_USER_WIDTH(UW), .MAX_BURST(MB), .LEN_WIDTH(LW))
        dut (.ACLK(ACLK), .ARESET(ARESET), .bus(bus));

    int total = 0;
    int bad   = 0;

    // Stimulus modes, owned by the main sequence.
    int ar_mode  = 0;   // 0 always ready, 1 random, 2 hold low 5 cycles
    int r_mode   = 0;   // 0 RVALID whenever possible, 1 random gaps
    int rr_mode  = 0;   // 0 rd_ready always 1, 1 toggle, 2 random
    int err_beat = 0;   // 1-based beat of the request that gets RRESP=SLVERR, 0 = none
    bit err_rand = 1'b0;

    // Monitor-owned observations.
    int cyc = 0;
    int done_cnt = 0;
    int words_rx = 0;
    logic [31:0] ar_log_a[$];
    int          ar_log_l[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents as a function of word address.
    function automatic logic [31:0] memw(input logic [WAW-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Beats of the next burst: limited by words left, MAX_BURST and the 4 KB page.
    function automatic int burst_beats(input logic [WAW-1:0] a, input int r);
        int room;
        int b;
        room = 1024 - int'(a[9:0]);
        b = r;
        if (b > MB) b = MB;
        if (b > room) b = room;
        return b;
    endfunction

    // Memory slave and word consumer: observe at negedge, drive just after posedge.
    initial begin : slave
        logic hs_ar, hs_r, acc;
        logic [31:0] ar_a;
        logic [7:0]  ar_l;
        logic s_act;
        logic [WAW-1:0] s_addr;
        int s_len, s_idx, ar_hi, req_beats;
        s_act = 0; s_addr = '0; s_len = 0; s_idx = 0; ar_hi = 0; req_beats = 0;
        bus.ARREADY_i = 0; bus.RVALID_i = 0; bus.RDATA_i = '0; bus.RRESP_i = 0;
        bus.RLAST_i = 0; bus.RID_i = 16'h1234; bus.RUSER_i = 10'h2AA; bus.rd_ready_i = 1;
        forever begin
            @(negedge ACLK);
            hs_ar = bus.ARVALID_o & bus.ARREADY_i;
            ar_a  = bus.ARADDR_o;
            ar_l  = bus.ARLEN_o;
            hs_r  = bus.RVALID_i & bus.RREADY_o;
            acc   = bus.rd_req_i & ~bus.rd_busy_o;
            @(posedge ACLK);
            #1;
            if (ARESET) begin
                s_act = 0; ar_hi = 0; req_beats = 0;
                bus.ARREADY_i = 0; bus.RVALID_i = 0; bus.RLAST_i = 0;
                continue;
            end
            if (acc) req_beats = 0;
            if (hs_r) begin
                s_idx++;
                req_beats++;
                if (s_idx == s_len) s_act = 0;
            end
            if (hs_ar) begin
                s_act = 1; s_addr = ar_a[31:2]; s_len = int'(ar_l) + 1; s_idx = 0; ar_hi = 0;
            end
            if (bus.ARVALID_o) ar_hi++; else ar_hi = 0;
            case (ar_mode)
                0: bus.ARREADY_i = 1;
                1: bus.ARREADY_i = ($urandom % 3 == 0);
                default: bus.ARREADY_i = (ar_hi > 5);
            endcase
            if (s_act) begin
                if (!(bus.RVALID_i && !hs_r)) begin
                    if (r_mode == 0 || $urandom % 4 != 0) begin
                        bus.RVALID_i = 1;
                        bus.RDATA_i  = memw(s_addr + WAW'(s_idx));
                        bus.RLAST_i  = (s_idx == s_len - 1);
                        if (err_beat != 0 && req_beats + 1 == err_beat) bus.RRESP_i = 2'b10;
                        else if (err_rand && $urandom % 10 == 0) bus.RRESP_i = ($urandom % 2 == 0) ? 2'b10 : 2'b11;
                        else bus.RRESP_i = ($urandom % 2 == 0) ? 2'b00 : 2'b01;
                    end else begin
                        bus.RVALID_i = 0;
                        bus.RLAST_i  = 0;
                    end
                end
            end else begin
                bus.RVALID_i = 0;
                bus.RLAST_i  = 0;
            end
            case (rr_mode)
                0: bus.rd_ready_i = 1;
                1: bus.rd_ready_i = ~bus.rd_ready_i;
                default: bus.rd_ready_i = ($urandom % 3 != 0);
            endcase
        end
    end

    // Model and compare process: checks every cycle against queues built at accept.
    initial begin : mon
        logic [31:0] exp_ar_a[$];
        int          exp_ar_l[$];
        logic [31:0] exp_w[$];
        logic m_busy, exp_err, err_n, prev_done, prev_arv, prev_arr, data_st, r_hs;
        logic [31:0] prev_ara, ea;
        logic [7:0]  prev_arl;
        logic [WAW-1:0] a;
        int burst_left, acc_cyc, acc_len, last_beat_cyc, r, b;
        m_busy = 0; exp_err = 0; prev_done = 0; prev_arv = 0; prev_arr = 0;
        prev_ara = '0; prev_arl = '0; burst_left = 0; acc_cyc = 0; acc_len = 0; last_beat_cyc = 0;
        forever begin
            @(negedge ACLK);
            cyc++;
            if (ARESET) begin
                exp_ar_a.delete(); exp_ar_l.delete(); exp_w.delete();
                m_busy = 0; exp_err = 0; prev_done = 0; prev_arv = 0; prev_arr = 0; burst_left = 0;
                continue;
            end
            data_st = bus.rd_busy_o & ~bus.ARVALID_o & ~bus.rd_done_o;
            r_hs    = bus.RVALID_i & bus.RREADY_o;
            err_n   = exp_err;
            chk("busy", bus.rd_busy_o, m_busy);
            chk("rready", bus.RREADY_o, data_st & bus.rd_ready_i);
            chk("rd_valid", bus.rd_valid_o, data_st & bus.RVALID_i);
            chk("rd_err", bus.rd_err_o, exp_err);
            if (bus.rd_valid_o) chk("rd_data_pass", bus.rd_data_o, bus.RDATA_i);
            if (prev_arv && !prev_arr) begin
                chk("arvalid_hold", bus.ARVALID_o, 1'b1);
                chk("araddr_hold", bus.ARADDR_o, prev_ara);
                chk("arlen_hold", bus.ARLEN_o, prev_arl);
            end
            if (bus.ARVALID_o) chk("ar_while_outstanding", burst_left, 0);
            if (bus.ARVALID_o && bus.ARREADY_i) begin
                ar_log_a.push_back(bus.ARADDR_o);
                ar_log_l.push_back(int'(bus.ARLEN_o));
                burst_left = int'(bus.ARLEN_o) + 1;
                if (exp_ar_a.size() == 0) begin
                    chk("ar_unexpected", exp_ar_a.size(), 1);
                end else begin
                    chk("araddr", bus.ARADDR_o, exp_ar_a.pop_front());
                    chk("arlen", bus.ARLEN_o, exp_ar_l.pop_front());
                end
            end
            if (r_hs) begin
                words_rx++;
                burst_left--;
                last_beat_cyc = cyc;
                if (exp_w.size() == 0) chk("word_unexpected", exp_w.size(), 1);
                else chk("word", bus.rd_data_o, exp_w.pop_front());
                if (ERR_EN && bus.RRESP_i[1]) err_n = 1;
            end
            if (bus.rd_done_o) begin
                done_cnt++;
                chk("done_while_idle", m_busy, 1'b1);
                chk("done_one_cycle", prev_done, 1'b0);
                chk("done_words_left", exp_w.size(), 0);
                chk("done_ars_left", exp_ar_a.size(), 0);
                chk("done_latency", cyc, (acc_len == 0) ? acc_cyc + 1 : last_beat_cyc + 1);
                m_busy = 0;
            end
            if (bus.rd_req_i && !bus.rd_busy_o) begin
                a = bus.rd_word_addr_i;
                r = int'(bus.rd_len_i);
                exp_w.delete(); exp_ar_a.delete(); exp_ar_l.delete();
                ar_log_a.delete(); ar_log_l.delete();
                for (int i = 0; i < r; i++) exp_w.push_back(memw(a + WAW'(i)));
                while (r > 0) begin
                    b  = burst_beats(a, r);
                    ea = {a, 2'b00};
                    exp_ar_a.push_back(ea);
                    exp_ar_l.push_back(b - 1);
                    a = a + WAW'(b);
                    r = r - b;
                end
                acc_cyc = cyc;
                acc_len = int'(bus.rd_len_i);
                m_busy  = 1;
                err_n   = 0;
            end
            exp_err   = err_n;
            prev_done = bus.rd_done_o;
            prev_arv  = bus.ARVALID_o;
            prev_arr  = bus.ARREADY_i;
            prev_ara  = bus.ARADDR_o;
            prev_arl  = bus.ARLEN_o;
        end
    end

    // Issue one request and wait, bounded, for its rd_done_o pulse.
    task automatic do_req(input logic [WAW-1:0] a, input logic [LW-1:0] n, input int budget);
        int d0;
        bit got;
        @(posedge ACLK);
        #1;
        d0 = done_cnt;
        bus.rd_req_i = 1; bus.rd_word_addr_i = a; bus.rd_len_i = n;
        @(posedge ACLK);
        #1;
        bus.rd_req_i = 0; bus.rd_word_addr_i = WAW'($urandom); bus.rd_len_i = LW'($urandom);
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge ACLK);
            #1;
            if (done_cnt != d0) got = 1;
        end
        chk("done_timeout", got, 1'b1);
    endtask

    initial begin : main
        int w0;
        bit got;
        bus.rd_req_i = 0; bus.rd_word_addr_i = '0; bus.rd_len_i = '0;
        ARESET = 1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_arvalid", bus.ARVALID_o, 1'b0);
        chk("rst_rready", bus.RREADY_o, 1'b0);
        chk("rst_rd_valid", bus.rd_valid_o, 1'b0);
        chk("rst_busy", bus.rd_busy_o, 1'b0);
        chk("rst_done", bus.rd_done_o, 1'b0);
        chk("rst_err", bus.rd_err_o, 1'b0);
        chk("rst_arlen", bus.ARLEN_o, 8'd0);
        @(posedge ACLK);
        #1;
        ARESET = 0;

        // Pin the burst model with hand-computed values.
        chk("model_b0_40", burst_beats(30'h0, 40), 16);
        chk("model_b32_8", burst_beats(30'd32, 8), 8);
        chk("model_b3fc_8", burst_beats(30'h3FC, 8), 4);
        chk("model_wrap", burst_beats(30'h3FFF_FFFE, 4), 2);

        // Single word, everything immediate.
        w0 = words_rx;
        do_req(30'h100, 1, 200);
        chk("t1_ar_count", ar_log_a.size(), 1);
        if (ar_log_a.size() == 1) begin
            chk("t1_araddr", ar_log_a[0], 32'h400);
            chk("t1_arlen", ar_log_l[0], 0);
        end
        chk("t1_words", words_rx - w0, 1);

        // 40 words split by MAX_BURST.
        w0 = words_rx;
        do_req(30'h0, 40, 500);
        chk("t2_ar_count", ar_log_a.size(), 3);
        if (ar_log_a.size() == 3) begin
            chk("t2_araddr0", ar_log_a[0], 32'h0);
            chk("t2_arlen0", ar_log_l[0], 15);
            chk("t2_araddr1", ar_log_a[1], 32'h40);
            chk("t2_arlen1", ar_log_l[1], 15);
            chk("t2_araddr2", ar_log_a[2], 32'h80);
            chk("t2_arlen2", ar_log_l[2], 7);
        end
        chk("t2_words", words_rx - w0, 40);

        // 4 KB split.
        do_req(30'h3FC, 8, 300);
        chk("t3_ar_count", ar_log_a.size(), 2);
        if (ar_log_a.size() == 2) begin
            chk("t3_araddr0", ar_log_a[0], 32'hFF0);
            chk("t3_arlen0", ar_log_l[0], 3);
            chk("t3_araddr1", ar_log_a[1], 32'h1000);
            chk("t3_arlen1", ar_log_l[1], 3);
        end

        // ARREADY held off 5 cycles, consumer toggling.
        ar_mode = 2; r_mode = 1; rr_mode = 1;
        w0 = words_rx;
        do_req(30'h200, 20, 800);
        chk("t4_ar_count", ar_log_a.size(), 2);
        chk("t4_words", words_rx - w0, 20);

        // Zero-length request: no AR traffic.
        ar_mode = 0; r_mode = 0; rr_mode = 0;
        do_req(30'h777, 0, 50);
        chk("t5_ar_count", ar_log_a.size(), 0);

        // SLVERR on beat 3 of 4.
        err_beat = 3;
        w0 = words_rx;
        do_req(30'h50, 4, 200);
        @(negedge ACLK);
        chk("t6_err_after", bus.rd_err_o, ERR_EN);
        chk("t6_words", words_rx - w0, 4);
        err_beat = 0;
        do_req(30'h60, 2, 200);
        @(negedge ACLK);
        chk("t6_err_cleared", bus.rd_err_o, 1'b0);

        // Word-address wrap at the top of the address space.
        do_req(30'h3FFF_FFFE, 4, 200);
        chk("t7_ar_count", ar_log_a.size(), 2);
        if (ar_log_a.size() == 2) begin
            chk("t7_araddr0", ar_log_a[0], 32'hFFFF_FFF8);
            chk("t7_araddr1", ar_log_a[1], 32'h0);
        end

        // Randomized requests and timing.
        for (int k = 0; k < 25; k++) begin
            logic [WAW-1:0] ra;
            ar_mode  = int'($urandom_range(0, 2));
            r_mode   = int'($urandom_range(0, 1));
            rr_mode  = int'($urandom_range(0, 2));
            err_rand = ($urandom % 2 == 0);
            ra = WAW'($urandom);
            if ($urandom % 2 == 0) ra[9:0] = 10'h3E0 + 10'($urandom_range(0, 31));
            do_req(ra, LW'($urandom_range(0, 48)), 2000);
        end
        err_rand = 0;

        // Reset during DATA, then a short request afterwards.
        ar_mode = 0; r_mode = 1; rr_mode = 2;
        w0 = words_rx;
        @(posedge ACLK);
        #1;
        bus.rd_req_i = 1; bus.rd_word_addr_i = 30'h10; bus.rd_len_i = 50;
        @(posedge ACLK);
        #1;
        bus.rd_req_i = 0;
        got = 0;
        for (int i = 0; i < 500 && !got; i++) begin
            @(posedge ACLK);
            #1;
            if (words_rx - w0 >= 5) got = 1;
        end
        chk("t8_progress_timeout", got, 1'b1);
        ARESET = 1;
        #1;
        chk("t8_rst_arvalid", bus.ARVALID_o, 1'b0);
        chk("t8_rst_rready", bus.RREADY_o, 1'b0);
        chk("t8_rst_rd_valid", bus.rd_valid_o, 1'b0);
        chk("t8_rst_busy", bus.rd_busy_o, 1'b0);
        chk("t8_rst_done", bus.rd_done_o, 1'b0);
        chk("t8_rst_err", bus.rd_err_o, 1'b0);
        chk("t8_rst_arlen", bus.ARLEN_o, 8'd0);
        repeat (2) @(posedge ACLK);
        #1;
        ARESET = 0;
        w0 = words_rx;
        do_req(30'h20, 2, 200);
        chk("t8_ar_count", ar_log_a.size(), 1);
        chk("t8_words", words_rx - w0, 2);

        repeat (3) @(posedge ACLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
